object_slot_manager: RTL
========================

OBJECT_SLOT_MANAGER -- requirements
Module: object_slot_manager

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 8, meaning object table depth (power of two, 2..16).
REQ-002 SHALL have parameter OBJ_SIZE, default 32, meaning object bounding-box edge in pixels.
REQ-003 SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port resetN  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have load port:
- load_valid  in  1  write request.
- load_slot  in  $clog2(NUM_SLOTS)  target slot.
- load_x, load_y  in  11 each  top-left position.
- load_type  in  4  object type.
- load_ready  out  1  write accepted.
REQ-006 SHALL have grab port:
- grab_req  in  1  start hit scan.
- hook_x, hook_y  in  11 each  hook tip position.
- grab_done  out  1  one-cycle result pulse.
- grab_hit  out  1  hit flag.
- grab_slot  out  $clog2(NUM_SLOTS)  hit slot.
- grab_type  out  4  hit slot type.
REQ-007 SHALL have held-object port:
- follow_valid  in  1  position update strobe.
- follow_x, follow_y  in  11 each  new top-left of held object.
- release  in  1  held object collected.
- held_valid  out  1  an object is held.
- collected_type  out  4  type of the collected object.
- collected_pulse  out  1  one-cycle collect strobe.
REQ-008 SHALL have render read port:
- render_idx  in  $clog2(NUM_SLOTS)  slot to read.
- render_x, render_y  out  11 each  that slot's top-left.
- render_type  out  4  that slot's type.

Function
REQ-009 SHALL keep per slot x[10:0], y[10:0] and type[3:0]; type 0 (FILLER) means empty.
REQ-010 SHALL drive the render outputs combinationally from slot render_idx, with zero latency.
REQ-011 SHALL implement FSM IDLE -> SCAN -> (HELD if hit, else IDLE); HELD -> IDLE on release.
REQ-012 SHALL assert load_ready = (state==IDLE); a load writes the slot on the edge where load_valid && load_ready.
REQ-013 SHALL, in IDLE on grab_req, capture hook_x/hook_y and enter SCAN; a load on the same edge is committed before the scan reads it.
REQ-014 SHALL, in SCAN, test one slot per cycle, indices 0..NUM_SLOTS-1.
REQ-015 SHALL count a slot as hit when type!=0, x<=hx<x+OBJ_SIZE and y<=hy<y+OBJ_SIZE.
REQ-016 SHALL do the REQ-015 compares 12 bits wide so x+OBJ_SIZE does not wrap.
REQ-017 SHALL latch the lowest-index hit; later hits are ignored.
REQ-018 SHALL pulse grab_done exactly NUM_SLOTS+1 cycles after the grab_req edge, independent of hit position.
REQ-019 SHALL hold grab_hit, grab_slot and grab_type stable from grab_done until the next grab_done; on a miss, grab_slot=0 and grab_type=0.
REQ-020 SHALL ignore grab_req in SCAN and HELD.
REQ-021 SHALL, in HELD, write follow_x/follow_y into the held slot on each follow_valid; held_valid=1 only in HELD.
REQ-022 SHALL, in HELD on release, clear the held slot type to 0, output its prior type on collected_type for exactly that cycle's collected_pulse, and return to IDLE.
REQ-023 SHALL give release priority over follow_valid when both occur on the same edge.
REQ-024 SHALL ignore release outside HELD.

Reset
REQ-025 SHALL, on resetN low, asynchronously:
- clear all slots to x=0, y=0, type=0;
- set state=IDLE;
- clear grab_done, grab_hit, grab_slot, grab_type, collected_pulse, collected_type and held_valid.
REQ-026 SHALL abandon any scan or held object on reset mid-operation, with no grab_done or collected_pulse.

Configuration
REQ-027 SHALL, with VALUABLE_COUNTER_EN defined, keep valuables_left[4:0] (slots with type 1..3), updated on load and release.
REQ-028 SHALL, with VALUABLE_COUNTER_EN defined, pulse level_clear for one cycle when a release takes valuables_left to 0.
REQ-029 SHALL, without VALUABLE_COUNTER_EN, keep both ports and tie them to 0.

Structure
REQ-030 SHALL take the object-type enum (FILLER, VALUABLE_1..3, ROCK_1), OBJECT_WIDTH/HEIGHT and TRANSPARENT_ENCODING from shared package goldminer_pkg.
REQ-031 SHALL put the REQ-015 point-in-box compare in sub-module obj_hit_test (combinational, also reusable by the renderer).

Verification
REQ-032 Bench SHALL cover these directed scenarios:
- Load slot 3 (100,200,type 1), grab at (110,210) -> grab_done at cycle 9, grab_hit=1, grab_slot=3, grab_type=1, held_valid=1.
- Grab at (132,210) against the same slot (x edge) -> grab_done with grab_hit=0, state back in IDLE.
- Slots 1 and 5 overlap at the hook -> grab_slot=1; grab_req during SCAN has no effect.
- HELD: follow (50,60) then release with follow_valid on the same edge -> render_idx=3 shows (50,60), type 0; collected_type=1 for one cycle.
- resetN low mid-SCAN -> all outputs 0, no grab_done; with VALUABLE_COUNTER_EN, the only valuable released -> level_clear pulse and valuables_left=0.

Source files
------------

// File: rtl/goldminer_pkg.sv
// Shared object definitions for the gold-miner playfield: object types, sprite geometry and
// small helpers used by the slot manager and the renderer.
package goldminer_pkg;

   typedef enum logic [3:0] {
      FILLER     = 4'd0,
      VALUABLE_1 = 4'd1,
      VALUABLE_2 = 4'd2,
      VALUABLE_3 = 4'd3,
      ROCK_1     = 4'd4
   } obj_type_e;

   localparam int unsigned OBJECT_WIDTH         = 32;
   localparam int unsigned OBJECT_HEIGHT        = 32;
   localparam logic [7:0]  TRANSPARENT_ENCODING = 8'hFF;

   typedef enum logic [1:0] {
      StIdle,
      StScan,
      StHeld
   } slot_state_e;

   function automatic logic is_valuable(input logic [3:0] t);
      return (t >= 4'(VALUABLE_1)) && (t <= 4'(VALUABLE_3));
   endfunction

endpackage

// File: rtl/obj_hit_test.sv
// Combinational point-in-box test against one object; an empty (FILLER) object never hits.
// Compares are done 12 bits wide so the far edge cannot wrap.
module obj_hit_test
   import goldminer_pkg::*;
#(
   parameter int unsigned BOX_W = OBJECT_WIDTH,
   parameter int unsigned BOX_H = OBJECT_HEIGHT
) (
   input  logic [10:0] obj_x_i,
   input  logic [10:0] obj_y_i,
   input  logic [3:0]  obj_type_i,
   input  logic [10:0] pt_x_i,
   input  logic [10:0] pt_y_i,
   output logic        hit_o
);

   logic [11:0] x0, y0, x1, y1, px, py;

   always_comb begin
      x0    = {1'b0, obj_x_i};
      y0    = {1'b0, obj_y_i};
      x1    = x0 + 12'(BOX_W);
      y1    = y0 + 12'(BOX_H);
      px    = {1'b0, pt_x_i};
      py    = {1'b0, pt_y_i};
      hit_o = (obj_type_i != 4'(FILLER)) && (x0 <= px) && (px < x1) && (y0 <= py) && (py < y1);
   end

endmodule

// File: rtl/object_slot_manager.sv
// Object table with load, sequential hook hit scan, held-object tracking and render read port.
// Optional macro VALUABLE_COUNTER_EN enables the valuables_left / level_clear counter.
module object_slot_manager
   import goldminer_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = 8,
   parameter int unsigned OBJ_SIZE  = OBJECT_WIDTH
) (
   input  logic                         clk,
   input  logic                         resetN,
   input  logic                         load_valid,
   input  logic [$clog2(NUM_SLOTS)-1:0] load_slot,
   input  logic [10:0]                  load_x,
   input  logic [10:0]                  load_y,
   input  logic [3:0]                   load_type,
   output logic                         load_ready,
   input  logic                         grab_req,
   input  logic [10:0]                  hook_x,
   input  logic [10:0]                  hook_y,
   output logic                         grab_done,
   output logic                         grab_hit,
   output logic [$clog2(NUM_SLOTS)-1:0] grab_slot,
   output logic [3:0]                   grab_type,
   input  logic                         follow_valid,
   input  logic [10:0]                  follow_x,
   input  logic [10:0]                  follow_y,
   input  logic                         release_req,
   output logic                         held_valid,
   output logic [3:0]                   collected_type,
   output logic                         collected_pulse,
   input  logic [$clog2(NUM_SLOTS)-1:0] render_idx,
   output logic [10:0]                  render_x,
   output logic [10:0]                  render_y,
   output logic [3:0]                   render_type,
   output logic [4:0]                   valuables_left,
   output logic                         level_clear
);

   localparam int unsigned IW = $clog2(NUM_SLOTS);
   localparam int unsigned CW = IW + 1;

   slot_state_e state_q, state_d;
   logic [10:0] x_q   [NUM_SLOTS];
   logic [10:0] x_d   [NUM_SLOTS];
   logic [10:0] y_q   [NUM_SLOTS];
   logic [10:0] y_d   [NUM_SLOTS];
   logic [3:0]  typ_q [NUM_SLOTS];
   logic [3:0]  typ_d [NUM_SLOTS];

   logic [10:0]   hook_x_q, hook_x_d, hook_y_q, hook_y_d;
   logic [CW-1:0] scan_cnt_q, scan_cnt_d;
   logic          hit_found_q, hit_found_d;
   logic [IW-1:0] hit_slot_q, hit_slot_d;
   logic [3:0]    hit_type_q, hit_type_d;
   logic          grab_done_q, grab_done_d, grab_hit_q, grab_hit_d;
   logic [IW-1:0] grab_slot_q, grab_slot_d;
   logic [3:0]    grab_type_q, grab_type_d;
   logic          held_valid_q, held_valid_d;
   logic [3:0]    collected_type_q, collected_type_d;
   logic          collected_pulse_q, collected_pulse_d;

   logic [IW-1:0] scan_idx;
   logic          scan_hit;

   assign scan_idx = scan_cnt_q[IW-1:0];

   obj_hit_test #(
      .BOX_W(OBJ_SIZE),
      .BOX_H(OBJ_SIZE)
   ) u_hit (
      .obj_x_i   (x_q[scan_idx]),
      .obj_y_i   (y_q[scan_idx]),
      .obj_type_i(typ_q[scan_idx]),
      .pt_x_i    (hook_x_q),
      .pt_y_i    (hook_y_q),
      .hit_o     (scan_hit)
   );

   always_comb begin
      state_d           = state_q;
      x_d               = x_q;
      y_d               = y_q;
      typ_d             = typ_q;
      hook_x_d          = hook_x_q;
      hook_y_d          = hook_y_q;
      scan_cnt_d        = scan_cnt_q;
      hit_found_d       = hit_found_q;
      hit_slot_d        = hit_slot_q;
      hit_type_d        = hit_type_q;
      grab_done_d       = 1'b0;
      grab_hit_d        = grab_hit_q;
      grab_slot_d       = grab_slot_q;
      grab_type_d       = grab_type_q;
      collected_type_d  = 4'd0;
      collected_pulse_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (load_valid) begin
               x_d[load_slot]   = load_x;
               y_d[load_slot]   = load_y;
               typ_d[load_slot] = load_type;
            end
            if (grab_req) begin
               hook_x_d    = hook_x;
               hook_y_d    = hook_y;
               scan_cnt_d  = '0;
               hit_found_d = 1'b0;
               hit_slot_d  = '0;
               hit_type_d  = 4'd0;
               state_d     = StScan;
            end
         end
         StScan: begin
            // One extra cycle after the last slot fixes the result latency at NUM_SLOTS+1.
            if (scan_cnt_q == CW'(NUM_SLOTS)) begin
               grab_done_d = 1'b1;
               grab_hit_d  = hit_found_q;
               grab_slot_d = hit_slot_q;
               grab_type_d = hit_type_q;
               state_d     = hit_found_q ? StHeld : StIdle;
            end else begin
               if (scan_hit && !hit_found_q) begin
                  hit_found_d = 1'b1;
                  hit_slot_d  = scan_idx;
                  hit_type_d  = typ_q[scan_idx];
               end
               scan_cnt_d = scan_cnt_q + CW'(1);
            end
         end
         StHeld: begin
            if (release_req) begin
               typ_d[grab_slot_q] = 4'(FILLER);
               collected_type_d   = typ_q[grab_slot_q];
               collected_pulse_d  = 1'b1;
               state_d            = StIdle;
            end else if (follow_valid) begin
               x_d[grab_slot_q] = follow_x;
               y_d[grab_slot_q] = follow_y;
            end
         end
         default: state_d = StIdle;
      endcase

      held_valid_d = (state_d == StHeld);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q           <= StIdle;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            x_q[i]   <= '0;
            y_q[i]   <= '0;
            typ_q[i] <= '0;
         end
         hook_x_q          <= '0;
         hook_y_q          <= '0;
         scan_cnt_q        <= '0;
         hit_found_q       <= 1'b0;
         hit_slot_q        <= '0;
         hit_type_q        <= '0;
         grab_done_q       <= 1'b0;
         grab_hit_q        <= 1'b0;
         grab_slot_q       <= '0;
         grab_type_q       <= '0;
         held_valid_q      <= 1'b0;
         collected_type_q  <= '0;
         collected_pulse_q <= 1'b0;
      end else begin
         state_q           <= state_d;
         x_q               <= x_d;
         y_q               <= y_d;
         typ_q             <= typ_d;
         hook_x_q          <= hook_x_d;
         hook_y_q          <= hook_y_d;
         scan_cnt_q        <= scan_cnt_d;
         hit_found_q       <= hit_found_d;
         hit_slot_q        <= hit_slot_d;
         hit_type_q        <= hit_type_d;
         grab_done_q       <= grab_done_d;
         grab_hit_q        <= grab_hit_d;
         grab_slot_q       <= grab_slot_d;
         grab_type_q       <= grab_type_d;
         held_valid_q      <= held_valid_d;
         collected_type_q  <= collected_type_d;
         collected_pulse_q <= collected_pulse_d;
      end
   end

   assign load_ready      = (state_q == StIdle);
   assign grab_done       = grab_done_q;
   assign grab_hit        = grab_hit_q;
   assign grab_slot       = grab_slot_q;
   assign grab_type       = grab_type_q;
   assign held_valid      = held_valid_q;
   assign collected_type  = collected_type_q;
   assign collected_pulse = collected_pulse_q;
   assign render_x        = x_q[render_idx];
   assign render_y        = y_q[render_idx];
   assign render_type     = typ_q[render_idx];

`ifdef VALUABLE_COUNTER_EN
   logic [4:0] val_q, val_d;
   logic       level_clear_q, level_clear_d;

   // Loads and releases are mutually exclusive (IDLE vs HELD), so one update per cycle suffices.
   always_comb begin
      val_d         = val_q;
      level_clear_d = 1'b0;
      if (state_q == StIdle && load_valid) begin
         val_d = val_q + {4'd0, is_valuable(load_type)} - {4'd0, is_valuable(typ_q[load_slot])};
      end
      if (state_q == StHeld && release_req && is_valuable(typ_q[grab_slot_q])) begin
         val_d         = val_q - 5'd1;
         level_clear_d = (val_q == 5'd1);
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         val_q         <= '0;
         level_clear_q <= 1'b0;
      end else begin
         val_q         <= val_d;
         level_clear_q <= level_clear_d;
      end
   end

   assign valuables_left = val_q;
   assign level_clear    = level_clear_q;
`else
   assign valuables_left = 5'd0;
   assign level_clear    = 1'b0;
`endif

endmodule
